// File: rtl/pe_ec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pe_ec_seq
//  Description : Time-multiplexed binary conv/pool/binarize processing element.
//                It accumulates per-kernel XNOR-popcounts over N_SLICE channel
//                beats, then max-pools across the POOL_H*POOL_W kernel
//                positions and binarizes against a normalisation threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_ec_seq #(
  parameter  int D_SLICE       = 64,
  parameter  int N_SLICE       = 8,
  parameter  int FH            = 3,
  parameter  int FW            = 3,
  parameter  int POOL_H        = 2,
  parameter  int POOL_W        = 2,
  parameter  int NORMREF_WIDTH = 14,
  localparam int N_KERNEL      = POOL_H * POOL_W,
  localparam int SW            = FH * FW * D_SLICE,
  localparam int K             = SW * N_SLICE,
  localparam int ACC_W         = $clog2(K + 1),
  localparam int PINDEX_WIDTH  = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_KERNEL*SW-1:0]          data_in,
  input  logic [SW-1:0]                   weight_in,
  input  logic signed [NORMREF_WIDTH-1:0] norm_ref,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            data_out,
  output logic [ACC_W-1:0]                pmax,
  output logic [PINDEX_WIDTH-1:0]         pindex
);

  localparam int PC_W  = $clog2(SW + 1);
  localparam int CNT_W = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;
  // Wide enough that K + norm_ref and the zero-extended pmax never overflow.
  localparam int THR_W = ACC_W + NORMREF_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_SLICE - 1);

  typedef enum logic [1:0] {
    S_ACC    = 2'd0,
    S_REDUCE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic signed [NORMREF_WIDTH-1:0]  norm_q, norm_d;
  logic [ACC_W-1:0]                 acc_q [N_KERNEL];
  logic [ACC_W-1:0]                 acc_d [N_KERNEL];
  logic [ACC_W-1:0]                 pmax_q, pmax_d;
  logic [PINDEX_WIDTH-1:0]          pindex_q, pindex_d;
  logic                             dout_q, dout_d;

  logic [PC_W-1:0]                  w_pc [N_KERNEL];
  logic                             w_accept;
  logic                             w_first;
  logic                             w_last;
  logic [ACC_W-1:0]                 w_max;
  logic [PINDEX_WIDTH-1:0]          w_idx;
  logic signed [THR_W-1:0]          w_sum;
  logic signed [THR_W-1:0]          w_thr;
  logic signed [THR_W-1:0]          w_pmax_s;
  logic                             w_bin;

  function automatic logic [PC_W-1:0] popcount(input logic [SW-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < SW; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // Kernel 0 sits in the most significant field of data_in.
  for (genvar k = 0; k < N_KERNEL; k++) begin : g_kernel
    assign w_pc[k] = popcount(~(data_in[(N_KERNEL-k)*SW-1 -: SW] ^ weight_in));
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign data_out  = dout_q;
  assign pmax      = pmax_q;
  assign pindex    = pindex_q;

  assign w_accept = in_valid && (state_q == S_ACC);
  assign w_first  = (cnt_q == '0);
  assign w_last   = (cnt_q == LAST_BEAT);

  // Next-state, beat counter and norm_ref capture on the first beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    norm_d  = norm_q;
    unique case (state_q)
      S_ACC: begin
        if (w_accept) begin
          if (w_first) begin
            norm_d = norm_ref;
          end
          if (w_last) begin
            cnt_d   = '0;
            state_d = S_REDUCE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_REDUCE: state_d = S_HOLD;
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // Per-kernel accumulators: first beat of a window loads, later beats add.
  always_comb begin
    for (int k = 0; k < N_KERNEL; k++) begin
      acc_d[k] = acc_q[k];
      if (w_accept) begin
        acc_d[k] = w_first ? ACC_W'(w_pc[k]) : acc_q[k] + ACC_W'(w_pc[k]);
      end
    end
  end

  // Max-pool with lowest-index tie break, then threshold compare.
  always_comb begin
    w_max = acc_q[0];
    w_idx = '0;
    for (int k = 1; k < N_KERNEL; k++) begin
      if (acc_q[k] > w_max) begin
        w_max = acc_q[k];
        w_idx = PINDEX_WIDTH'(k);
      end
    end
    w_sum    = THR_W'(K) + {{(THR_W-NORMREF_WIDTH){norm_q[NORMREF_WIDTH-1]}}, norm_q};
    w_thr    = w_sum >>> 1;
    w_pmax_s = {{(THR_W-ACC_W){1'b0}}, w_max};
    w_bin    = (w_pmax_s >= w_thr);
  end

  // Result registers only change in REDUCE so they stay stable afterwards.
  always_comb begin
    pmax_d   = pmax_q;
    pindex_d = pindex_q;
    dout_d   = dout_q;
    if (state_q == S_REDUCE) begin
      pmax_d   = w_max;
      pindex_d = w_idx;
      dout_d   = w_bin;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset discards any partially accumulated window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      norm_q   <= '0;
      pmax_q   <= '0;
      pindex_q <= '0;
      dout_q   <= 1'b0;
      for (int k = 0; k < N_KERNEL; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      norm_q   <= norm_d;
      pmax_q   <= pmax_d;
      pindex_q <= pindex_d;
      dout_q   <= dout_d;
      for (int k = 0; k < N_KERNEL; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_ec_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pe_ec_seq
//  Description : Directed and randomised self-checking bench for pe_ec_seq
//                (D_SLICE=8, N_SLICE=4, 3x3 filter, 2x2 pool).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_ec_seq;
  localparam int D_SLICE = 8;
  localparam int N_SLICE = 4;
  localparam int NRW     = 14;
  localparam int NK      = 4;
  localparam int SW      = 72;
  localparam int K       = 288;
  localparam int ACC_W   = 9;
  localparam int PW      = 2;
  localparam int DW      = NK * SW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [DW-1:0]         data_in = '0;
  logic [SW-1:0]         weight_in = '0;
  logic signed [NRW-1:0] norm_ref = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic                  data_out;
  logic [ACC_W-1:0]      pmax;
  logic [PW-1:0]         pindex;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] md [N_SLICE];
  logic [SW-1:0] mw [N_SLICE];

  pe_ec_seq #(
    .D_SLICE(D_SLICE), .N_SLICE(N_SLICE), .FH(3), .FW(3),
    .POOL_H(2), .POOL_W(2), .NORMREF_WIDTH(NRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .weight_in(weight_in), .norm_ref(norm_ref),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .pmax(pmax), .pindex(pindex)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [SW-1:0] rand_sw();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[SW-1:0];
  endfunction

  function automatic logic [DW-1:0] pack4(input logic [SW-1:0] f0, f1, f2, f3);
    return {f0, f1, f2, f3};
  endfunction

  // Reference: popcount sums, max with lowest-index ties, floor threshold.
  task automatic model(input logic signed [NRW-1:0] nr, output logic ed,
                       output logic [ACC_W-1:0] ep, output logic [PW-1:0] ei);
    int acc [NK];
    int best, bi, thr;
    for (int k = 0; k < NK; k++) begin
      acc[k] = 0;
      for (int b = 0; b < N_SLICE; b++) begin
        acc[k] += $countones(~(md[b][(NK-k)*SW-1 -: SW] ^ mw[b]));
      end
    end
    best = acc[0]; bi = 0;
    for (int k = 1; k < NK; k++) begin
      if (acc[k] > best) begin best = acc[k]; bi = k; end
    end
    thr = (K + int'(nr)) >>> 1;
    ed = (best >= thr);
    ep = ACC_W'(best);
    ei = PW'(bi);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] w,
                           input logic signed [NRW-1:0] nr);
    int t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    data_in = d; weight_in = w; norm_ref = nr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends the window held in md/mw; later beats carry a decoy norm_ref.
  task automatic send_window(input logic signed [NRW-1:0] nr0,
                             input logic signed [NRW-1:0] nr_late, input int max_gap);
    for (int b = 0; b < N_SLICE; b++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      send_beat(md[b], mw[b], (b == 0) ? nr0 : nr_late);
    end
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 30) begin @(posedge clk); #1; t++; end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_during out_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL reset data_out: got %b want 0", data_out); end
    checks++; if (pmax !== '0) begin errors++; $display("FAIL reset pmax: got %0d want 0", pmax); end
    checks++; if (pindex !== '0) begin errors++; $display("FAIL reset pindex: got %0d want 0", pindex); end
  endtask

  task automatic test_all_match();
    for (int b = 0; b < N_SLICE; b++) begin
      mw[b] = rand_sw();
      md[b] = pack4(mw[b], mw[b], mw[b], mw[b]);
    end
    send_window(14'sd0, 14'sd0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency early out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reduce in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency out_valid: got %b want 1", out_valid); end
    checks++; if (pmax !== 9'd288) begin errors++; $display("FAIL all_match pmax: got %0d want 288", pmax); end
    checks++; if (pindex !== 2'd0) begin errors++; $display("FAIL all_match pindex: got %0d want 0", pindex); end
    checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL all_match data_out: got %b want 1", data_out); end
    ack();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ack out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ack in_ready: got %b want 1", in_ready); end
    checks++; if (pmax !== 9'd288) begin errors++; $display("FAIL retain pmax: got %0d want 288", pmax); end
  endtask

  task automatic test_kernel_select();
    logic [SW-1:0] w;
    for (int b = 0; b < N_SLICE; b++) begin
      w = rand_sw(); mw[b] = w;
      md[b] = pack4(~w, ~w, w, ~w);
    end
    send_window(14'sd0, 14'sd0, 0);
    wait_out();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL kernel2 out_valid: got %b want 1", out_valid); end
    checks++; if (pmax !== 9'd288) begin errors++; $display("FAIL kernel2 pmax: got %0d want 288", pmax); end
    checks++; if (pindex !== 2'd2) begin errors++; $display("FAIL kernel2 pindex: got %0d want 2", pindex); end
    checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL kernel2 data_out: got %b want 1", data_out); end
    ack();
    for (int b = 0; b < N_SLICE; b++) begin
      w = rand_sw(); mw[b] = w;
      md[b] = pack4(~w, ~w, ~w, (b == N_SLICE-1) ? (w ^ 72'h1) : w);
    end
    send_window(14'sd0, 14'sd0, 0);
    wait_out();
    checks++; if (pmax !== 9'd287) begin errors++; $display("FAIL kernel3 pmax: got %0d want 287", pmax); end
    checks++; if (pindex !== 2'd3) begin errors++; $display("FAIL kernel3 pindex: got %0d want 3", pindex); end
    checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL kernel3 data_out: got %b want 1", data_out); end
    ack();
  endtask

  task automatic test_threshold();
    int nrs [4]   = '{289, 290, -288, -286};
    bit match [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int ep [4]    = '{288, 288, 0, 0};
    bit ed [4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [SW-1:0] w, f;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < N_SLICE; b++) begin
        w = rand_sw(); mw[b] = w;
        f = match[i] ? w : ~w;
        md[b] = pack4(f, f, f, f);
      end
      send_window(NRW'(nrs[i]), 14'sd0, 0);
      wait_out();
      checks++; if (pmax !== ACC_W'(ep[i])) begin errors++; $display("FAIL thr%0d pmax: got %0d want %0d", i, pmax, ep[i]); end
      checks++; if (pindex !== 2'd0) begin errors++; $display("FAIL thr%0d pindex: got %0d want 0", i, pindex); end
      checks++; if (data_out !== ed[i]) begin errors++; $display("FAIL thr%0d data_out norm_ref=%0d: got %b want %b", i, nrs[i], data_out, ed[i]); end
      ack();
    end
  endtask

  task automatic test_handshake();
    logic ed; logic [ACC_W-1:0] ep; logic [PW-1:0] ei;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL idle_ready in_ready/out_valid: got %b/%b want 1/0", in_ready, out_valid); end
    end
    out_ready = 1'b0;
    for (int b = 0; b < N_SLICE; b++) begin
      mw[b] = rand_sw();
      md[b] = pack4(rand_sw(), mw[b] ^ 72'hF, rand_sw(), ~mw[b]);
    end
    model(14'sd20, ed, ep, ei);
    send_window(14'sd20, -14'sd2000, 3);
    wait_out();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps out_valid: got %b want 1", out_valid); end
    checks++; if (pmax !== ep) begin errors++; $display("FAIL gaps pmax: got %0d want %0d", pmax, ep); end
    checks++; if (pindex !== ei) begin errors++; $display("FAIL gaps pindex: got %0d want %0d", pindex, ei); end
    checks++; if (data_out !== ed) begin errors++; $display("FAIL norm_hold data_out: got %b want %b", data_out, ed); end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || pmax !== ep || pindex !== ei || data_out !== ed) begin
        errors++;
        $display("FAIL stall v/r/pmax/pidx/d: got %b/%b/%0d/%0d/%b want 1/0/%0d/%0d/%b",
                 out_valid, in_ready, pmax, pindex, data_out, ep, ei, ed);
      end
    end
    ack();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL release in_ready/out_valid: got %b/%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] w;
    logic ed; logic [ACC_W-1:0] ep; logic [PW-1:0] ei;
    for (int b = 0; b < 2; b++) begin
      w = rand_sw();
      send_beat(pack4(w, w, w, w), w, 14'sd0);
    end
    #3 rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset in_ready/out_valid: got %b/%b want 1/0", in_ready, out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < N_SLICE; b++) begin
      w = rand_sw(); mw[b] = w;
      md[b] = (b == 0) ? pack4(~w, w, ~w, ~w) : pack4(~w, ~w, ~w, ~w);
    end
    model(14'sd0, ed, ep, ei);
    send_window(14'sd0, 14'sd0, 0);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fresh out_valid: got %b want 1", out_valid); end
    checks++; if (pmax !== ep || ep !== 9'd72) begin errors++; $display("FAIL fresh pmax: got %0d want 72", pmax); end
    checks++; if (pindex !== 2'd1) begin errors++; $display("FAIL fresh pindex: got %0d want 1", pindex); end
    checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL fresh data_out: got %b want 0", data_out); end
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || pmax !== '0) begin errors++; $display("FAIL hold_reset out_valid/pmax: got %b/%0d want 0/0", out_valid, pmax); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic ed; logic [ACC_W-1:0] ep; logic [PW-1:0] ei;
    logic [SW-1:0] w, f [NK];
    logic signed [NRW-1:0] nr;
    int last_cyc = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      for (int b = 0; b < N_SLICE; b++) begin
        w = rand_sw(); mw[b] = w;
        for (int k = 0; k < NK; k++) begin
          case ($urandom_range(0, 3))
            0:       f[k] = w;
            1:       f[k] = ~w;
            default: f[k] = rand_sw();
          endcase
        end
        md[b] = pack4(f[0], f[1], f[2], f[3]);
      end
      nr = NRW'(int'($urandom_range(0, 120)) - 60);
      model(nr, ed, ep, ei);
      send_window(nr, NRW'($urandom()), 0);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || pmax !== ep || pindex !== ei || data_out !== ed) begin
        errors++;
        $display("FAIL b2b win%0d v/pmax/pidx/d: got %b/%0d/%0d/%b want 1/%0d/%0d/%b",
                 n, out_valid, pmax, pindex, data_out, ep, ei, ed);
      end
      if (n > 0) begin
        checks++;
        if (cyc - last_cyc != N_SLICE + 2) begin
          errors++;
          $display("FAIL b2b spacing win%0d: got %0d want %0d", n, cyc - last_cyc, N_SLICE + 2);
        end
      end
      last_cyc = cyc;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_kernel_select();
    test_threshold();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_ec_seq.md
Name: pe_ec_seq

Overview:
- Time-multiplexed successor to the combinational binary conv/pool/binarize PE.
- Channel depth arrives as N_SLICE beats of D_SLICE channels each. Per-kernel XNOR-popcounts are accumulated across beats.
- After the last beat: max-pool over POOL_H*POOL_W kernel positions, then binarize against a normalisation threshold.
- Sits between the line-buffer/window generator (upstream) and the output feature-map packer (downstream); valid/ready on both sides.

Parameters:
- D_SLICE, 64, channels per input beat
- N_SLICE, 8, beats per window; total depth D = D_SLICE*N_SLICE
- FH, 3, filter height
- FW, 3, filter width
- POOL_H, 2, pooling window height
- POOL_W, 2, pooling window width
- NORMREF_WIDTH, 14, signed width of norm_ref

Derived constants:
- N_KERNEL = POOL_H*POOL_W
- SW = FH*FW*D_SLICE
- K = SW*N_SLICE
- ACC_W = clog2(K+1)
- PINDEX_WIDTH = max(1, clog2(N_KERNEL))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- data_in  in  N_KERNEL*SW  fmap slice, pre-unrolled per kernel position; kernel k occupies MSB-first field k (k = i*POOL_W+j)
- weight_in  in  SW  weight slice, same bit ordering as one kernel field
- norm_ref  in  NORMREF_WIDTH  signed normalisation reference; sampled on the first beat of a window
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- data_out  out  1  binarized activation
- pmax  out  ACC_W  pooled popcount (debug/next-layer use)
- pindex  out  PINDEX_WIDTH  index of the winning kernel position

Behaviour:
- Reset (async, rst_n=0):
  - State=ACC, beat counter=0, all accumulators=0, norm register=0.
  - in_ready=1 after release; out_valid=0, data_out=0, pmax=0, pindex=0.
- FSM states:
  - ACC: in_ready=1. Beat accepted when in_valid&&in_ready.
    - Each accepted beat: acc[k] += popcount(~(data_in field k ^ weight_in)) for all k in parallel.
    - On beat 0, acc[k] loads that value instead of adding, and norm_ref is registered.
    - Beat counter increments; the beat with counter==N_SLICE-1 sets counter to 0 and goes to REDUCE.
    - in_valid low: state and counter hold (gaps allowed anywhere).
  - REDUCE: one cycle, in_ready=0.
    - Registers pmax = max(acc[k]), unsigned compare; ties resolve to the lowest k; that k goes to pindex.
    - Registers thr = floor((K + norm_ref)/2), signed, width ACC_W+NORMREF_WIDTH+1, arithmetic shift right.
    - data_out = ($signed({0,pmax}) >= thr).
    - Goes to HOLD and sets out_valid=1.
  - HOLD: out_valid=1, in_ready=0; data_out/pmax/pindex stable.
    - On out_ready: out_valid=0 next cycle, state=ACC.
- Latency: last beat accepted at edge t → out_valid high after edge t+1 (visible in cycle t+1..).
- Throughput: one window per N_SLICE+2 cycles with no stalls.
- Outputs retain their last values after handshake until the next REDUCE.
- norm_ref changes after beat 0 have no effect on the current window.
- out_ready high while out_valid=0: ignored.
- Reset mid-window: partial accumulation discarded; the next accepted beat is beat 0.
- Reset in HOLD: result dropped, out_valid=0.
- N_KERNEL=1: pindex constant 0, pmax=acc[0].
- N_SLICE=1: every accepted beat completes a window.

Test Plan:
- Default window config FH=FW=3, D_SLICE=8, N_SLICE=4, POOL 2x2 (K=288, ACC_W=9). Every kernel field equal to weight_in on all 4 beats, norm_ref=0 → pmax=288, pindex=0 (tie→lowest), thr=144, data_out=1, out_valid 1 cycle after beat-3 acceptance.
- Kernel 2 exact match, others fully inverted, norm_ref=0 → pmax=288, pindex=2, data_out=1. Kernel 3 matches on 3 beats plus 71/72 on the last, all others 0 → pmax=287, pindex=3.
- Threshold edges, all-match (pmax=288):
  - norm_ref=289 → thr=288, data_out=1.
  - norm_ref=290 → thr=289, data_out=0.
  - All-mismatch (pmax=0) with norm_ref=-288 → thr=0, data_out=1; with norm_ref=-286 → thr=1, data_out=0.
- Handshake stress: in_valid toggled randomly within a window → same result as gap-free. out_ready held low 5 cycles → out_valid, data_out, pmax, pindex stable and in_ready=0 throughout; out_ready=1 → in_ready=1 next cycle. norm_ref changed after beat 0 → result unchanged.
- Reset mid-window: pulse rst_n low after 2 beats → in_ready=1, out_valid=0. Next 4 beats form a fresh window with the correct result, and the pre-reset beats have no effect.
- Back-to-back windows with out_ready tied 1 → windows at N_SLICE+2 cycle spacing. Results match a reference model over 200 random windows with random norm_ref.
